// File: rtl/sysid_checker_pkg.sv
// Shared state encoding, slave word offsets and counter sizing for the
// system-ID checker master.
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Counters are sized for the widest legal timeout and latency settings
    localparam int TIMEOUT_MAX = 65535;
    localparam int LATENCY_MAX = 3;
    localparam int TO_CNT_W    = $clog2(TIMEOUT_MAX + 1);
    localparam int LAT_CNT_W   = $clog2(LATENCY_MAX + 1);

    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return (a == b);
    endfunction

endpackage

// File: rtl/sysid_checker_master.sv
// Avalon-MM read master that fetches the system-ID and build timestamp words
// and reports whether they match the values this image was built against.
module sysid_checker_master
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1486252493,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam bit                   HAS_LAT  = (READ_LATENCY > 0);
    localparam logic [TO_CNT_W-1:0]  TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_CNT_W-1:0]  TO_ZERO  = {TO_CNT_W{1'b0}};
    localparam logic [TO_CNT_W-1:0]  TO_ONE   = TO_CNT_W'(1'b1);
    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(HAS_LAT ? READ_LATENCY - 1 : 0);
    localparam logic [LAT_CNT_W-1:0] LAT_ZERO = {LAT_CNT_W{1'b0}};
    localparam logic [LAT_CNT_W-1:0] LAT_ONE  = LAT_CNT_W'(1'b1);

    state_e               state_r;
    logic [TO_CNT_W-1:0]  to_cnt_r;
    logic [LAT_CNT_W-1:0] lat_cnt_r;
    logic                 in_rd_s;
    logic                 accept_s;
    logic                 expire_s;
    logic                 to_sat_s;
    logic                 lat_end_s;

    // Handshake and counter events for the current cycle
    always_comb begin
        in_rd_s   = (state_r == RD_ID) || (state_r == RD_TS);
        accept_s  = in_rd_s && !avm_waitrequest;
        // The stall that brings the count to TIMEOUT_CYCLES abandons the read
        expire_s  = in_rd_s && avm_waitrequest && (to_cnt_r >= TO_LAST);
        to_sat_s  = (to_cnt_r >= TO_LIMIT);
        lat_end_s = (lat_cnt_r == LAT_LAST);
    end

    // Check sequencer with registered bus strobes, status flags and captured words
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            to_cnt_r    <= TO_ZERO;
            lat_cnt_r   <= LAT_ZERO;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_match    <= 1'b0;
            ts_match    <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r     <= RD_ID;
                        to_cnt_r    <= TO_ZERO;
                        avm_address <= ADDR_ID;
                        avm_read    <= 1'b1;
                        busy        <= 1'b1;
                        id_match    <= 1'b0;
                        ts_match    <= 1'b0;
                        timeout     <= 1'b0;
                        id_value    <= 32'd0;
                        ts_value    <= 32'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_ID, RD_TS: begin
                    if (accept_s) begin
                        to_cnt_r <= TO_ZERO;
                        if (HAS_LAT) begin
                            state_r   <= (state_r == RD_ID) ? LAT_ID : LAT_TS;
                            avm_read  <= 1'b0;
                            lat_cnt_r <= LAT_ZERO;
                        end else if (state_r == RD_ID) begin
                            id_value    <= avm_readdata;
                            id_match    <= word_match(avm_readdata, EXPECTED_ID);
                            state_r     <= RD_TS;
                            avm_address <= ADDR_TS;
                        end else begin
                            ts_value <= avm_readdata;
                            ts_match <= word_match(avm_readdata, EXPECTED_TIMESTAMP);
                            state_r  <= DONE;
                            avm_read <= 1'b0;
                            done     <= 1'b1;
                        end
                    end else if (expire_s) begin
                        timeout  <= 1'b1;
                        state_r  <= DONE;
                        avm_read <= 1'b0;
                        done     <= 1'b1;
                    end else if (!to_sat_s) begin
                        to_cnt_r <= to_cnt_r + TO_ONE;
                    end else begin
                        to_cnt_r <= to_cnt_r;
                    end
                end
                LAT_ID: begin
                    if (lat_end_s) begin
                        id_value    <= avm_readdata;
                        id_match    <= word_match(avm_readdata, EXPECTED_ID);
                        state_r     <= RD_TS;
                        to_cnt_r    <= TO_ZERO;
                        avm_address <= ADDR_TS;
                        avm_read    <= 1'b1;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_ONE;
                    end
                end
                LAT_TS: begin
                    if (lat_end_s) begin
                        ts_value <= avm_readdata;
                        ts_match <= word_match(avm_readdata, EXPECTED_TIMESTAMP);
                        state_r  <= DONE;
                        done     <= 1'b1;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_ONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker_master.sv
// Self-checking bench: two checker instances (zero latency / default timeout,
// and latency 2 / timeout 4) driven by a stalling slave model.
module tb_sysid_checker_master;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1486252493;

    typedef struct {
        int          u;
        logic [31:0] d0;
        logic [31:0] d1;
        int          w0;
        int          w1;
        bit          extra;
        int          e_done;
        logic [31:0] e_id;
        logic [31:0] e_ts;
        bit          e_idm;
        bit          e_tsm;
        bit          e_to;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [1:0]  wr = 2'b00;
    logic [1:0]  rd, addr, busy, done, idm, tsm, tmo;
    logic [31:0] rdata [2];
    logic [31:0] idv [2];
    logic [31:0] tsv [2];

    logic [31:0] sdata [2][2];
    int          wcfg [2][2];
    int          seen [2][2];
    int          pend_lat [2] = '{0, 0};
    logic        lat_addr [2];

    bit          exp_read [$];
    bit          exp_addr [$];
    vec_t        vecs [$];
    int          vectors = 0;
    int          n_checks = 0;
    int          miscompares = 0;

    always #5 clock = ~clock;

    sysid_checker_master #(.EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
                           .READ_LATENCY(0), .TIMEOUT_CYCLES(255)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start[0]),
        .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wr[0]),
        .avm_readdata(rdata[0]), .busy(busy[0]), .done(done[0]),
        .id_match(idm[0]), .ts_match(tsm[0]), .timeout(tmo[0]),
        .id_value(idv[0]), .ts_value(tsv[0]));

    sysid_checker_master #(.EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
                           .READ_LATENCY(2), .TIMEOUT_CYCLES(4)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start[1]),
        .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wr[1]),
        .avm_readdata(rdata[1]), .busy(busy[1]), .done(done[1]),
        .id_match(idm[1]), .ts_match(tsm[1]), .timeout(tmo[1]),
        .id_value(idv[1]), .ts_value(tsv[1]));

    function automatic int lat_of(input int u);
        return (u == 1) ? 2 : 0;
    endfunction

    function automatic int tmo_of(input int u);
        return (u == 1) ? 4 : 255;
    endfunction

    // Slave: stalls wcfg cycles per offset, returns garbage except when data is due
    always @(negedge clock) begin
        for (int u = 0; u < 2; u++) begin
            if (pend_lat[u] > 0) begin
                pend_lat[u] = pend_lat[u] - 1;
                wr[u] = 1'b0;
                rdata[u] = (pend_lat[u] == 0) ? sdata[u][lat_addr[u]] : $urandom;
            end else if (rd[u] === 1'b1) begin
                if (seen[u][addr[u]] < wcfg[u][addr[u]]) begin
                    wr[u] = 1'b1;
                    seen[u][addr[u]] = seen[u][addr[u]] + 1;
                    rdata[u] = $urandom;
                end else begin
                    wr[u] = 1'b0;
                    if (lat_of(u) == 0) begin
                        rdata[u] = sdata[u][addr[u]];
                    end else begin
                        rdata[u] = $urandom;
                        pend_lat[u] = lat_of(u);
                        lat_addr[u] = addr[u];
                    end
                end
            end else begin
                wr[u] = 1'b0;
                rdata[u] = $urandom;
                seen[u][0] = 0;
                seen[u][1] = 0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: per-cycle read/address trace plus final result of one check
    task automatic model(input int u, input int w0, input int w1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         output int dn, output logic [31:0] id, output logic [31:0] ts,
                         output bit im, output bit tm, output bit to);
        int ws [2];
        bit got [2];
        bit dead;
        ws = '{w0, w1};
        got = '{1'b0, 1'b0};
        dead = 1'b0;
        exp_read.delete();
        exp_addr.delete();
        for (int w = 0; w < 2; w++) begin
            if (!dead) begin
                if (ws[w] >= tmo_of(u)) begin
                    repeat (tmo_of(u)) begin exp_read.push_back(1'b1); exp_addr.push_back(w[0]); end
                    dead = 1'b1;
                end else begin
                    repeat (ws[w] + 1) begin exp_read.push_back(1'b1); exp_addr.push_back(w[0]); end
                    repeat (lat_of(u)) begin exp_read.push_back(1'b0); exp_addr.push_back(1'b0); end
                    got[w] = 1'b1;
                end
            end
        end
        exp_read.push_back(1'b0);
        exp_addr.push_back(1'b0);
        dn = exp_read.size();
        id = got[0] ? d0 : 32'd0;
        ts = got[1] ? d1 : 32'd0;
        im = got[0] && (d0 == EXP_ID);
        tm = got[1] && (d1 == EXP_TS);
        to = dead;
    endtask

    function automatic vec_t mk(input int u, input logic [31:0] d0, input logic [31:0] d1,
                                input int w0, input int w1, input bit extra, input int dn,
                                input logic [31:0] id, input logic [31:0] ts,
                                input bit im, input bit tm, input bit to);
        vec_t v;
        v.u = u; v.d0 = d0; v.d1 = d1; v.w0 = w0; v.w1 = w1; v.extra = extra;
        v.e_done = dn; v.e_id = id; v.e_ts = ts; v.e_idm = im; v.e_tsm = tm; v.e_to = to;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string nm);
        int dn, n_done, done_at, trace_bad;
        logic [31:0] mid, mts;
        bit mim, mtm, mto;
        int u;
        u = v.u;
        sdata[u][0] = v.d0;
        sdata[u][1] = v.d1;
        wcfg[u][0] = v.w0;
        wcfg[u][1] = v.w1;
        model(u, v.w0, v.w1, v.d0, v.d1, dn, mid, mts, mim, mtm, mto);
        repeat (3) @(negedge clock);
        start[u] = 1'b1;
        n_done = 0;
        done_at = -1;
        trace_bad = 0;
        for (int c = 1; c <= v.e_done + 1; c++) begin
            @(negedge clock);
            // Optional extra starts land while busy and in the DONE cycle
            start[u] = v.extra && (c == 1 || c == v.e_done);
            if (done[u] === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            if (c <= dn) begin
                if (busy[u] !== 1'b1 || rd[u] !== exp_read[c-1] ||
                    (exp_read[c-1] && addr[u] !== exp_addr[c-1]))
                    trace_bad++;
            end
        end
        start[u] = 1'b0;
        vectors++;
        check({nm, "_trace"}, trace_bad, 0);
        check({nm, "_done_at"}, done_at, v.e_done);
        check({nm, "_done_pulses"}, n_done, 1);
        check({nm, "_busy_after"}, {31'd0, busy[u]}, 32'd0);
        check({nm, "_id_value"}, idv[u], v.e_id);
        check({nm, "_ts_value"}, tsv[u], v.e_ts);
        check({nm, "_id_match"}, {31'd0, idm[u]}, {31'd0, v.e_idm});
        check({nm, "_ts_match"}, {31'd0, tsm[u]}, {31'd0, v.e_tsm});
        check({nm, "_timeout"}, {31'd0, tmo[u]}, {31'd0, v.e_to});
    endtask

    task automatic chk_zero(input int u, input string nm);
        check({nm, "_flags"}, {25'd0, rd[u], addr[u], busy[u], done[u], idm[u], tsm[u], tmo[u]}, 32'd0);
        check({nm, "_id_value"}, idv[u], 32'd0);
        check({nm, "_ts_value"}, tsv[u], 32'd0);
    endtask

    // Start a check on unit u and pull reset asynchronously at cycle at_c
    task automatic reset_mid(input int u, input int w0, input int at_c, input string nm);
        sdata[u][0] = EXP_ID;
        sdata[u][1] = EXP_TS;
        wcfg[u][0] = w0;
        wcfg[u][1] = 0;
        repeat (3) @(negedge clock);
        start[u] = 1'b1;
        for (int c = 1; c <= at_c; c++) begin
            @(negedge clock);
            start[u] = 1'b0;
        end
        check({nm, "_busy_pre"}, {31'd0, busy[u]}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_zero(u, nm);
        vectors++;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int dn;
        logic [31:0] d0, d1, id, ts;
        bit im, tm, to;
        int u, w0, w1;
        for (int i = 0; i < 2; i++) begin
            sdata[i][0] = 32'd0; sdata[i][1] = 32'd0;
            wcfg[i][0] = 0; wcfg[i][1] = 0;
            seen[i][0] = 0; seen[i][1] = 0;
        end
        repeat (3) @(negedge clock);
        chk_zero(0, "reset_u0");
        chk_zero(1, "reset_u1");
        reset_n = 1'b1;

        vecs.push_back(mk(0, EXP_ID, EXP_TS, 0, 0, 1'b0, 3, EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(0, 32'h0000_0001, EXP_TS, 0, 0, 1'b1, 3, 32'h0000_0001, EXP_TS, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1, EXP_ID, EXP_TS, 3, 3, 1'b0, 13, EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1, EXP_ID, EXP_TS, 0, 1000, 1'b0, 8, EXP_ID, 32'd0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1, EXP_ID, EXP_TS, 1000, 0, 1'b0, 5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1, EXP_ID, 32'd0, 3, 0, 1'b1, 10, EXP_ID, 32'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(0, EXP_ID, EXP_TS + 32'd1, 254, 0, 1'b0, 257, EXP_ID, EXP_TS + 32'd1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(0, EXP_ID, EXP_TS, 255, 0, 1'b0, 256, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(0, 32'hFFFF_FFFF, EXP_TS, 0, 255, 1'b0, 257, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 24; i++) begin
            u  = $urandom_range(0, 1);
            d0 = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            d1 = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            if (u == 1) begin
                w0 = $urandom_range(0, 5);
                w1 = $urandom_range(0, 5);
            end else begin
                w0 = ($urandom_range(0, 7) == 0) ? 300 : $urandom_range(0, 3);
                w1 = ($urandom_range(0, 7) == 0) ? 300 : $urandom_range(0, 3);
            end
            model(u, w0, w1, d0, d1, dn, id, ts, im, tm, to);
            vecs.push_back(mk(u, d0, d1, w0, w1, $urandom_range(0, 1) == 1, dn, id, ts, im, tm, to));
        end

        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

        reset_mid(1, 0, 2, "rst_lat_id");
        run_txn(vecs[2], "post_rst_lat");
        reset_mid(1, 3, 2, "rst_rd_stall");
        run_txn(vecs[0], "post_rst_rd");
        run_txn(mk(0, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 1'b0, 3,
                   32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 1'b0), "pre_rst_idle");
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 chk_zero(0, "rst_idle_u0");
        vectors++;
        @(negedge clock);
        reset_n = 1'b1;
        run_txn(vecs[1], "post_rst_idle");

        if (n_checks < 12) begin
            miscompares++;
            $display("FAIL check_count: got %0d, expected at least 12", n_checks);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
